// File: rtl/dmem_pkg.sv
// Shared types for the byte-lane data memory: access size, FSM state,
// registered request and the byte-enable helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        unsgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Little-endian lane select; half picks the upper pair when ofs[1] is set,
    // word ignores the offset entirely.
    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] ofs);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << ofs;
            SZ_HALF: byte_en = ofs[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data onto all lanes with
// byte enables, and extracts/extends load data from the addressed word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic        unsgn,
    input  logic [1:0]  ofs,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_lane,
    output logic [3:0]  be,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Replicated store data lets the enables alone pick the target lane.
    always_comb begin
        be         = byte_en(size, ofs);
        wdata_lane = 32'h0;
        rdata      = 32'h0;
        shifted    = rword >> {ofs, 3'b000};
        rbyte      = shifted[7:0];
        rhalf      = ofs[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                wdata_lane = {4{wdata[7:0]}};
                rdata      = unsgn ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                wdata_lane = {2{wdata[15:0]}};
                rdata      = unsgn ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                wdata_lane = wdata;
                rdata      = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_byte_lane_ctrl.sv
// Word-organised data memory with byte/half/word access, sign/zero load
// extension, WAIT_STATES extra latency and a post-reset zero sweep.
// Optional: define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_byte_lane_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [1:0]  Req_Size,
    input  logic        Req_Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Resp_Valid,
    output logic [31:0] ReadData,
    output logic        Error,
    output logic [15:0] TestValue
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state;
    logic [AW-1:0] sweep_idx;
    logic [3:0]  wait_cnt;
    req_t        req;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic        range_err, size_err, align_err, err;
    logic [31:0] wdata_lane, rdata;
    logic [3:0]  be;

    assign idx       = req.addr[AW+1:2];
    assign range_err = |req.addr[31:AW+2];
    assign size_err  = (req.size == SZ_RSVD);
`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = ((req.size == SZ_HALF) && req.addr[0]) ||
                       ((req.size == SZ_WORD) && (req.addr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif
    assign err       = range_err | size_err | align_err;

    assign Req_Ready = (state == ST_IDLE);
    assign TestValue = mem[0][15:0];

    dmem_lane_align u_align (
        .size       (req.size),
        .unsgn      (req.unsgn),
        .ofs        (req.addr[1:0]),
        .wdata      (req.wdata),
        .rword      (mem[idx]),
        .wdata_lane (wdata_lane),
        .be         (be),
        .rdata      (rdata)
    );

    // Control FSM: sweep, accept, wait-state countdown, one-cycle response.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_INIT;
            sweep_idx  <= '0;
            wait_cnt   <= '0;
            req        <= '0;
            Resp_Valid <= 1'b0;
            ReadData   <= 32'h0;
            Error      <= 1'b0;
        end else begin
            Resp_Valid <= 1'b0;
            ReadData   <= 32'h0;
            Error      <= 1'b0;
            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == AW'(DEPTH_WORDS - 1)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (Req_Valid) begin
                        req <= '{write: Req_Write, size: size_e'(Req_Size),
                                 unsgn: Req_Unsigned, addr: Address, wdata: WriteData};
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) state <= ST_RESP;
                    else                  wait_cnt <= wait_cnt - 1'b1;
                end
                ST_RESP: begin
                    Resp_Valid <= 1'b1;
                    Error      <= err;
                    ReadData   <= (!req.write && !err) ? rdata : 32'h0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // RAM: sweep clears one word per cycle; stores commit on the edge leaving RESP.
    always_ff @(posedge Clock) begin
        if (state == ST_INIT) begin
            mem[sweep_idx] <= 32'h0;
        end else if (state == ST_RESP && req.write && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_byte_lane_ctrl.sv
// Scoreboard bench: the driver pushes expected responses (data, error,
// arrival cycle); a negedge monitor pops and compares on every Resp_Valid.
module tb_dmem_byte_lane_ctrl;

    localparam int DEPTH = 256;
    localparam int WS    = 3;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_Write = 1'b0;
    logic [1:0]  Req_Size = 2'b00;
    logic        Req_Unsigned = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        Resp_Valid;
    logic [31:0] ReadData;
    logic        Error;
    logic [15:0] TestValue;

    dmem_byte_lane_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Req_Valid    (Req_Valid),
        .Req_Ready    (Req_Ready),
        .Req_Write    (Req_Write),
        .Req_Size     (Req_Size),
        .Req_Unsigned (Req_Unsigned),
        .Address      (Address),
        .WriteData    (WriteData),
        .Resp_Valid   (Resp_Valid),
        .ReadData     (ReadData),
        .Error        (Error),
        .TestValue    (TestValue)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int id_n  = 0;
    int last_acc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Reset && Resp_Valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got data=%h err=%b want no response", ReadData, Error);
            end else begin
                e = sbq.pop_front();
                check($sformatf("resp%0d_data", e.id), ReadData, e.data);
                check($sformatf("resp%0d_err", e.id), {31'h0, Error}, {31'h0, e.err});
                check($sformatf("resp%0d_cycle", e.id), cyc, e.cyc);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following accept.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee,
                         input bit hold, input bit expect_resp);
        int n = 0;
        Req_Write = w; Req_Size = sz; Req_Unsigned = u; Address = a; WriteData = wd;
        Req_Valid = 1'b1;
        while (!Req_Ready && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!Req_Ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no Req_Ready want accept of addr %h", a);
            Req_Valid = 1'b0;
        end else begin
            @(posedge Clock);
            @(negedge Clock);
            last_acc = cyc;
            if (expect_resp) sbq.push_back('{ed, ee, cyc + WS + 1, id_n});
            id_n++;
            if (!hold) Req_Valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL resp_timeout: got %0d missing responses want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
        issue(w, sz, u, a, wd, ed, ee, 1'b0, 1'b1);
        drain();
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        while (!Req_Ready && n < 1000) begin
            n++;
            @(negedge Clock);
        end
        check(name, n, DEPTH);
    endtask

    int a0;

    initial begin
        repeat (3) @(negedge Clock);
        check("rst_ready", {31'h0, Req_Ready}, 32'h0);
        check("rst_resp_valid", {31'h0, Resp_Valid}, 32'h0);
        check("rst_readdata", ReadData, 32'h0);
        check("rst_error", {31'h0, Error}, 32'h0);
        Reset = 1'b1;
        wait_sweep("sweep_len");
        check("tv_after_sweep", {16'h0, TestValue}, 32'h0);

        // load of cleared word
        op(0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0);

        // store word then sub-word loads
        op(1, 2'b10, 0, 32'h8, 32'h8081_F27F, 32'h0, 0);
        op(0, 2'b00, 0, 32'h8, 32'h0, 32'h0000_007F, 0);
        op(0, 2'b00, 0, 32'hB, 32'h0, 32'hFFFF_FF80, 0);
        op(0, 2'b00, 1, 32'hB, 32'h0, 32'h0000_0080, 0);
        op(0, 2'b01, 0, 32'hA, 32'h0, 32'hFFFF_8081, 0);
        op(0, 2'b01, 1, 32'h8, 32'h0, 32'h0000_F27F, 0);
        op(0, 2'b10, 0, 32'h8, 32'h0, 32'h8081_F27F, 0);

        // byte store into word 0
        op(1, 2'b00, 0, 32'h1, 32'h0000_00AA, 32'h0, 0);
        check("tv_after_sb", {16'h0, TestValue}, 32'h0000_AA00);
        op(0, 2'b10, 0, 32'h0, 32'h0, 32'h0000_AA00, 0);

        // half store to upper lanes
        op(1, 2'b01, 0, 32'hE, 32'h1234_BEEF, 32'h0, 0);
        op(0, 2'b10, 0, 32'hC, 32'h0, 32'hBEEF_0000, 0);

        // held request: second accept only the cycle after the first response
        issue(0, 2'b10, 0, 32'h8, 32'h0, 32'h8081_F27F, 0, 1'b1, 1'b1);
        a0 = last_acc;
        issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h0000_AA00, 0, 1'b0, 1'b1);
        check("held_accept_gap", last_acc - a0, WS + 2);
        drain();

        // range and reserved-size errors leave memory unchanged
        op(1, 2'b10, 0, 32'h400, 32'hDEAD_BEEF, 32'h0, 1);
        op(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
        op(1, 2'b11, 0, 32'h0, 32'h1234_5678, 32'h0, 1);
        op(0, 2'b11, 0, 32'h8, 32'h0, 32'h0, 1);
        op(0, 2'b10, 0, 32'h0, 32'h0, 32'h0000_AA00, 0);
        check("tv_after_errors", {16'h0, TestValue}, 32'h0000_AA00);

        // misaligned accesses
        op(1, 2'b10, 0, 32'h4, 32'h1122_3344, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        op(0, 2'b10, 0, 32'h6, 32'h0, 32'h0, 1);
        op(0, 2'b01, 0, 32'h5, 32'h0, 32'h0, 1);
`else
        op(0, 2'b10, 0, 32'h6, 32'h0, 32'h1122_3344, 0);
        op(0, 2'b01, 0, 32'h5, 32'h0, 32'h0000_3344, 0);
`endif

        // reset during WAIT of a store: no response, store absent after re-sweep
        issue(1, 2'b10, 0, 32'h10, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 1'b0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("mid_reset_resp_valid", {31'h0, Resp_Valid}, 32'h0);
        Reset = 1'b1;
        wait_sweep("resweep_len");
        check("tv_after_resweep", {16'h0, TestValue}, 32'h0);
        op(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0);
        op(0, 2'b10, 0, 32'h8, 32'h0, 32'h0, 0);

        repeat (3) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
